// File: rtl/rstctrl.sv
// rstctrl - reset sequencer.
//
// Takes the soft-reset requests from the device table (rst0/rst1/rst2), the PLL
// lock and a board button. It produces:
//   - a system reset (sys_rst_o),
//   - a CPU-core reset (cpu_rst_o),
//   - a one-cycle FPGA reconfiguration trigger (reconf_o),
//   - a code giving the cause of the last reset (rstcause_o).
// sys_rst_o is fed back to the device table, which clears the requests.
//
// Ports:
//   clk_i        in   system clock
//   rst_n_i      in   asynchronous active-low reset
//   pll_locked_i in   PLL lock (async, 2-flop synchronized)
//   btn_n_i      in   board reset button, active-low (async, synchronized + debounced)
//   rst0_i       in   full soft-reset request (level)
//   rst1_i       in   reconfigure request (level)
//   rst2_i       in   CPU-only reset pulse (1 cycle)
//   sys_rst_o    out  active-high system reset
//   cpu_rst_o    out  active-high CPU-core reset
//   reconf_o     out  one-cycle multiboot/ICAP trigger pulse
//   rstcause_o   out  0 POR, 1 PLL, 2 BTN, 3 SOFT, 4 CPU, 5 RECONF
module rstctrl #(
  parameter int RSTHOLDCYC  = 16,
  parameter int DEBOUNCECYC = 65536,
  parameter int RECONFEN    = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       btn_n_i,
  input  logic       rst0_i,
  input  logic       rst1_i,
  input  logic       rst2_i,
  output logic       sys_rst_o,
  output logic       cpu_rst_o,
  output logic       reconf_o,
  output logic [2:0] rstcause_o
);

  localparam int CNT_W = (RSTHOLDCYC > 1) ? $clog2(RSTHOLDCYC) : 1;
  localparam int DB_W  = (DEBOUNCECYC > 1) ? $clog2(DEBOUNCECYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RSTHOLDCYC - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCECYC - 1);
  localparam logic [DB_W-1:0]  DB_PRE   = DB_W'(DEBOUNCECYC - 2);

  localparam logic [2:0] CAUSE_PLL    = 3'd1;
  localparam logic [2:0] CAUSE_BTN    = 3'd2;
  localparam logic [2:0] CAUSE_SOFT   = 3'd3;
  localparam logic [2:0] CAUSE_CPU    = 3'd4;
  localparam logic [2:0] CAUSE_RECONF = 3'd5;

  typedef enum logic [2:0] {
    S_LOCK,
    S_HOLD,
    S_RUN,
    S_CPUHOLD,
    S_RECONF
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  logic             done_q, done_d;
  logic             sys_rst_q, sys_rst_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             reconf_q, reconf_d;
  logic [2:0]       cause_q, cause_d;

  logic             lock_meta_q, lock_sync_q;
  logic             btn_meta_q, btn_sync_q;

  // Debounce: count consecutive low samples of the synchronized button. The
  // counter saturates at DB_MAX, so the press event fires only on the cycle
  // it first reaches DB_MAX. That gives exactly one event per press.
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (btn_sync_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_MAX) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    press_d = !btn_sync_q && (db_cnt_q == DB_PRE);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    cause_d  = cause_q;
    done_d   = done_q;
    reconf_d = 1'b0;

    case (state_q)
      S_LOCK: begin
        // Power-up / relock path: the cause code is left untouched.
        if (lock_sync_q) begin
          state_d = S_HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_RUN;
      end
      S_RUN: begin
        if (rst1_i) begin
          cnt_d = CNT_LOAD;
          if (RECONFEN != 0) begin
            state_d = S_RECONF;
            done_d  = 1'b0;
            cause_d = CAUSE_RECONF;
          end else begin
            state_d = S_HOLD;
            cause_d = CAUSE_SOFT;
          end
        end else if (rst0_i) begin
          state_d = S_HOLD;
          cnt_d   = CNT_LOAD;
          cause_d = CAUSE_SOFT;
        end else if (rst2_i) begin
          state_d = S_CPUHOLD;
          cnt_d   = CNT_LOAD;
          cause_d = CAUSE_CPU;
        end
      end
      S_CPUHOLD: begin
        if (cnt_q == '0) state_d = S_RUN;
      end
      S_RECONF: begin
        // Fire the trigger once when the hold expires, then park here with
        // both resets asserted until the FPGA reloads.
        if ((cnt_q == '0) && !done_q) begin
          reconf_d = 1'b1;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_LOCK;
      end
    endcase

    // PLL loss and button press preempt every state except LOCK, even
    // mid-count. A press while already in HOLD restarts the hold.
    if (state_q != S_LOCK) begin
      if (!lock_sync_q) begin
        state_d  = S_LOCK;
        cnt_d    = '0;
        cause_d  = CAUSE_PLL;
        reconf_d = 1'b0;
      end else if (press_q) begin
        state_d  = S_HOLD;
        cnt_d    = CNT_LOAD;
        cause_d  = CAUSE_BTN;
        reconf_d = 1'b0;
      end
    end

    // The outputs are registered from the next state. Each reset therefore
    // changes on the same edge as the state.
    sys_rst_d = (state_d != S_RUN) && (state_d != S_CPUHOLD);
    cpu_rst_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      state_q     <= S_LOCK;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      sys_rst_q   <= 1'b1;
      cpu_rst_q   <= 1'b1;
      reconf_q    <= 1'b0;
      cause_q     <= 3'd0;
    end else begin
      lock_meta_q <= pll_locked_i;
      lock_sync_q <= lock_meta_q;
      btn_meta_q  <= btn_n_i;
      btn_sync_q  <= btn_meta_q;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      sys_rst_q   <= sys_rst_d;
      cpu_rst_q   <= cpu_rst_d;
      reconf_q    <= reconf_d;
      cause_q     <= cause_d;
    end
  end

  assign sys_rst_o  = sys_rst_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign reconf_o   = reconf_q;
  assign rstcause_o = cause_q;

endmodule
